// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid pipeline stage with flush and backpressure counter
module pipe_skid_stage #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = {DATA_W{1'b0}},
    parameter int                 CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  bp_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;

    // Handshake outputs come only from registered state so neither side sees a
    // combinational path from the other.
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        out_data  = main_q;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        level     = 2'd0;
        case (state)
            EMPTY:   level = 2'd0;
            ONE:     level = 2'd1;
            FULL:    level = 2'd2;
            default: level = 2'd0;
        endcase
    end

    // Entry state machine; flush kills both entries and any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= NOP_VAL;
            skid_q <= NOP_VAL;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= NOP_VAL;
            skid_q <= NOP_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (out_fire) begin
                        main_q <= NOP_VAL;
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain matters.
                    if (out_fire) begin
                        main_q <= skid_q;
                        skid_q <= NOP_VAL;
                        state  <= ONE;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= NOP_VAL;
                    skid_q <= NOP_VAL;
                end
            endcase
        end
    end

    // Saturating count of cycles where a valid head is stalled; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_cnt <= '0;
        end else if (out_valid && !out_ready && (bp_cnt != {CNT_W{1'b1}})) begin
            bp_cnt <= bp_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed and scoreboarded checks for pipe_skid_stage
module tb_pipe_skid_stage;

    localparam int         DW  = 8;
    localparam logic [7:0] NOP = 8'hEE;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    level;
    logic [15:0]   bp_cnt;

    logic          s_in_valid;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_level;
    logic [2:0]    s_bp_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .bp_cnt(bp_cnt)
    );

    pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_data(8'h5A), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(1'b0),
        .level(s_level), .bp_cnt(s_bp_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    int         exp_bp;
    logic [7:0] exp_head;
    logic       m_ifire;
    logic       m_ofire;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
        s_in_valid = 1'b0;

        // Reset held two cycles with input offered
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_out_data", 32'(out_data), 32'(NOP));
        chk("rel_level", 32'(level), 32'd0);
        chk("rel_bp_cnt", 32'(bp_cnt), 32'd0);

        // Streaming: data k appears one cycle after it is offered
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            #1;
            chk("str_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("str_out_valid", 32'(out_valid), 32'd1);
            chk("str_out_data", 32'(out_data), 32'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain_valid", 32'(out_valid), 32'd0);
        chk("str_drain_data", 32'(out_data), 32'(NOP));
        chk("str_bp_cnt", 32'(bp_cnt), 32'd0);

        // Skid: A then B with downstream stalled
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
        tick();
        in_data = 8'hB2;
        tick();
        chk("skid_level", 32'(level), 32'd2);
        chk("skid_in_ready", 32'(in_ready), 32'd0);
        chk("skid_head_a", 32'(out_data), 32'hA1);
        chk("skid_bp_cnt", 32'(bp_cnt), 32'd1);
        in_data = 8'hCC; out_ready = 1'b1;
        tick();
        chk("skid_head_b", 32'(out_data), 32'hB2);
        chk("skid_level1", 32'(level), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("skid_empty_valid", 32'(out_valid), 32'd0);
        chk("skid_empty_data", 32'(out_data), 32'(NOP));

        // Flush in FULL with input offered and downstream ready
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        chk("fl_full", 32'(level), 32'd2);
        flush = 1'b1; in_data = 8'h33; out_ready = 1'b1;
        tick();
        chk("fl_level", 32'(level), 32'd0);
        chk("fl_data", 32'(out_data), 32'(NOP));
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_after_valid", 32'(out_valid), 32'd0);
        chk("fl_after_data", 32'(out_data), 32'(NOP));
        chk("fl_bp_cnt", 32'(bp_cnt), 32'd2);

        // Flush with stalled head still counts backpressure and does not clear it
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl2_level", 32'(level), 32'd0);
        chk("fl2_bp_cnt", 32'(bp_cnt), 32'd3);

        // Saturation on the narrow-counter instance
        s_in_valid = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("sat_bp_cnt", 32'(s_bp_cnt), 32'((i > 7) ? 7 : i));
        end
        chk("sat_level", 32'(s_level), 32'd2);
        chk("sat_head", 32'(s_out_data), 32'h5A);

        // Random traffic against a queue model
        exp_bp = 3;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_data   = 8'($urandom_range(0, 255));
            #1;
            exp_head = (q.size() > 0) ? q[0] : NOP;
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_out_data", 32'(out_data), 32'(exp_head));
            chk("rnd_level", 32'(level), 32'(q.size()));
            chk("rnd_bp_cnt", 32'(bp_cnt), 32'(exp_bp));
            m_ofire = (q.size() > 0) && out_ready;
            m_ifire = (q.size() < 2) && in_valid;
            if ((q.size() > 0) && !out_ready && (exp_bp < 65535)) exp_bp++;
            if (flush) begin
                q.delete();
            end else begin
                if (m_ofire) void'(q.pop_front());
                if (m_ifire) q.push_back(in_data);
            end
            tick();
        end

        // Mid-operation reset beats flush and handshakes
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_data", 32'(out_data), 32'(NOP));
        chk("mrst_bp_cnt", 32'(bp_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
